// File: rtl/neo_d0_outregs.sv
// neo_d0_outregs: 68k-written bank and output-port registers with per-channel pulse timers
module neo_d0_outregs #(
  parameter int NCH = 2,
  parameter int CW = 3,
  parameter int BANK_W = 3,
  parameter int DW = 8,
  parameter int SELW = 2,
  parameter int PULSE_LEN = 16
) (
  input  logic                CLK_24M,
  input  logic                nRESET,
  input  logic                nRESETP,
  input  logic                nBITWD0,
  input  logic [SELW-1:0]     M68K_ADDR_SEL,
  input  logic [DW-1:0]       M68K_DATA,
  output logic [BANK_W-1:0]   BNK,
  output logic [NCH*CW-1:0]   P_OUT,
  output logic                WR_ACK,
  output logic [NCH-1:0]      BUSY
);
  localparam logic [15:0] PLEN = 16'(PULSE_LEN);
  logic s1, s2, s3, v1, v2, armed, wr, mode_hit;
  logic [BANK_W-1:0] bank;
  logic [NCH-1:0] mode;
  logic [NCH*CW-1:0] p_reg;
  logic unused_ok;
  assign unused_ok = &{1'b0, M68K_DATA};
  assign wr = armed & ~s2 & s3;
  assign mode_hit = wr & (M68K_ADDR_SEL == SELW'(NCH + 1));
  assign BNK = nRESETP ? bank : '0;
  assign P_OUT = nRESETP ? p_reg : '0;
  // v2 marks s2 as holding a real strobe sample, so the reset value of the
  // synchroniser can never arm the edge detector
  always_ff @(posedge CLK_24M) begin
    if (!nRESET) begin
      {s1, s2, s3} <= '1;
      {v1, v2, armed} <= '0;
      bank <= '0;
      mode <= '0;
      WR_ACK <= 1'b0;
    end else begin
      s1 <= nBITWD0;
      s2 <= s1;
      s3 <= s2;
      v1 <= 1'b1;
      v2 <= v1;
      armed <= armed | (v2 & s2);
      WR_ACK <= wr & (M68K_ADDR_SEL <= SELW'(NCH + 1));
      if (wr && M68K_ADDR_SEL == '0) bank <= M68K_DATA[BANK_W-1:0];
      if (mode_hit) mode <= M68K_DATA[NCH-1:0];
    end
  end
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [CW-1:0] ch;
    logic [15:0] cnt;
    logic hit, nm;
    assign hit = wr & (M68K_ADDR_SEL == SELW'(k + 1));
    assign nm = M68K_DATA[k];
    assign p_reg[k*CW +: CW] = ch;
    assign BUSY[k] = cnt != '0;
    // a nonzero counter is the busy state; it only ever runs in pulse mode
    always_ff @(posedge CLK_24M) begin
      if (!nRESET) begin
        ch <= '0;
        cnt <= '0;
      end else if (hit) begin
        ch <= M68K_DATA[CW-1:0];
        cnt <= (mode[k] && M68K_DATA[CW-1:0] != '0) ? PLEN : '0;
      end else if (mode_hit && mode[k] && !nm) begin
        cnt <= '0;
      end else if (mode_hit && !mode[k] && nm) begin
        cnt <= (ch != '0) ? PLEN : '0;
      end else if (cnt != '0) begin
        cnt <= cnt - 16'd1;
        if (cnt == 16'd1) ch <= '0;
      end
    end
  end
endmodule

// File: tb/tb_neo_d0_outregs.sv
// tb_neo_d0_outregs: scoreboard bench; expected register state is queued per write and checked on WR_ACK
module tb_neo_d0_outregs;
  typedef struct packed {
    logic [2:0] b;
    logic [5:0] p;
    logic [1:0] bz;
  } exp_t;

  logic clk = 1'b0;
  logic nreset, nresetp, nb, nb3;
  logic [1:0] sel;
  logic [2:0] sel3;
  logic [7:0] data;
  logic [2:0] bnk, bnk3;
  logic [5:0] p_out, p_out3;
  logic wr_ack, wr_ack3;
  logic [1:0] busy, busy3;

  exp_t q[$];
  exp_t mon_e;
  int tests = 0, fails = 0;
  int ack_cnt = 0, exp_acks = 0, ack3_cnt = 0, busy_run = 0;

  always #5 clk = ~clk;

  neo_d0_outregs dut (
    .CLK_24M(clk), .nRESET(nreset), .nRESETP(nresetp), .nBITWD0(nb),
    .M68K_ADDR_SEL(sel), .M68K_DATA(data), .BNK(bnk), .P_OUT(p_out),
    .WR_ACK(wr_ack), .BUSY(busy)
  );

  neo_d0_outregs #(.SELW(3)) u3 (
    .CLK_24M(clk), .nRESET(nreset), .nRESETP(nresetp), .nBITWD0(nb3),
    .M68K_ADDR_SEL(sel3), .M68K_DATA(data), .BNK(bnk3), .P_OUT(p_out3),
    .WR_ACK(wr_ack3), .BUSY(busy3)
  );

  always @(negedge clk) begin
    if (busy[1]) busy_run++;
    if (wr_ack3) ack3_cnt++;
    if (wr_ack) begin
      ack_cnt++;
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ack: got bnk=%h p_out=%h busy=%b, no write pending", bnk, p_out, busy);
      end else begin
        mon_e = q.pop_front();
        if ({bnk, p_out, busy} !== mon_e) begin
          fails++;
          $display("FAIL ack_state: got bnk=%h p_out=%h busy=%b, want bnk=%h p_out=%h busy=%b",
                   bnk, p_out, busy, mon_e.b, mon_e.p, mon_e.bz);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] s, input logic [7:0] d, input logic [2:0] eb,
                    input logic [5:0] ep, input logic [1:0] ebz, input int lo = 3, input int hi = 3);
    q.push_back('{b: eb, p: ep, bz: ebz});
    exp_acks++;
    sel = s;
    data = d;
    nb = 1'b0;
    repeat (lo) @(negedge clk);
    nb = 1'b1;
    repeat (hi) @(negedge clk);
  endtask

  task automatic wr3(input logic [2:0] s, input logic [7:0] d);
    sel3 = s;
    data = d;
    nb3 = 1'b0;
    repeat (3) @(negedge clk);
    nb3 = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a0;
    nreset = 1'b0; nresetp = 1'b1; nb = 1'b1; nb3 = 1'b1;
    sel = '0; sel3 = '0; data = '0;
    repeat (3) @(negedge clk);
    chk("reset_bnk", 32'(bnk), 0);
    chk("reset_pout", 32'(p_out), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_ack", 32'(wr_ack), 0);
    nreset = 1'b1;
    repeat (5) @(negedge clk);
    // bank writes, upper data bits ignored
    wr(2'd0, 8'h05, 3'd5, 6'h00, 2'b00);
    chk("bank_one_ack", 32'(ack_cnt), 1);
    wr(2'd0, 8'hFA, 3'd2, 6'h00, 2'b00);
    // level-mode channel 0 held, then output gate
    wr(2'd1, 8'h06, 3'd2, 6'h06, 2'b00);
    repeat (1000) @(negedge clk);
    chk("level_hold", 32'(p_out), 32'h06);
    nresetp = 1'b0;
    #1;
    chk("gate_bnk", 32'(bnk), 0);
    chk("gate_pout", 32'(p_out), 0);
    nresetp = 1'b1;
    #1;
    chk("ungate_pout", 32'(p_out), 32'h06);
    chk("ungate_bnk", 32'(bnk), 2);
    @(negedge clk);
    // long strobe gives exactly one write
    a0 = ack_cnt;
    wr(2'd2, 8'h01, 3'd2, 6'h0E, 2'b00, 50, 3);
    chk("long_strobe_acks", 32'(ack_cnt - a0), 1);
    wr(2'd2, 8'h00, 3'd2, 6'h06, 2'b00);
    // sel=3 is the mode register; channel 1 is zero so no pulse starts
    wr(2'd3, 8'h02, 3'd2, 6'h06, 2'b00);
    busy_run = 0;
    wr(2'd2, 8'h03, 3'd2, 6'h1E, 2'b10, 3, 20);
    chk("pulse_len", 32'(busy_run), 16);
    chk("pulse_end_pout", 32'(p_out), 32'h06);
    chk("pulse_end_busy", 32'(busy), 0);
    // retrigger ten clocks after the first update
    busy_run = 0;
    wr(2'd2, 8'h03, 3'd2, 6'h1E, 2'b10, 3, 7);
    wr(2'd2, 8'h05, 3'd2, 6'h2E, 2'b10, 3, 30);
    chk("retrig_len", 32'(busy_run), 26);
    chk("retrig_end_pout", 32'(p_out), 32'h06);
    // zero write in pulse mode stops the timer at once
    wr(2'd2, 8'h04, 3'd2, 6'h26, 2'b10);
    wr(2'd2, 8'h00, 3'd2, 6'h06, 2'b00);
    // pulse->level keeps the register, level->pulse with nonzero register starts a pulse
    wr(2'd2, 8'h04, 3'd2, 6'h26, 2'b10);
    wr(2'd3, 8'h00, 3'd2, 6'h26, 2'b00);
    repeat (20) @(negedge clk);
    chk("to_level_hold", 32'(p_out), 32'h26);
    wr(2'd3, 8'h02, 3'd2, 6'h26, 2'b10);
    // reset in the middle of that pulse
    chk("midpulse_busy", 32'(busy), 32'b10);
    nreset = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_pout", 32'(p_out), 0);
    chk("rst_mid_bnk", 32'(bnk), 0);
    // strobe held low across reset release must never write
    a0 = ack_cnt;
    sel = 2'd0;
    data = 8'h07;
    nb = 1'b0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    repeat (10) @(negedge clk);
    chk("held_low_bnk", 32'(bnk), 0);
    chk("held_low_acks", 32'(ack_cnt - a0), 0);
    nb = 1'b1;
    repeat (4) @(negedge clk);
    wr(2'd0, 8'h03, 3'd3, 6'h00, 2'b00);
    // wider select: 1 hits channel 0, 5 is unmapped
    wr3(3'd1, 8'h03);
    chk("sel3_ch0", 32'(p_out3), 32'h03);
    chk("sel3_acks", 32'(ack3_cnt), 1);
    wr3(3'd5, 8'h07);
    chk("sel5_acks", 32'(ack3_cnt), 1);
    chk("sel5_pout", 32'(p_out3), 32'h03);
    chk("sel5_bnk", 32'(bnk3), 0);
    repeat (4) @(negedge clk);
    chk("total_acks", 32'(ack_cnt), 32'(exp_acks));
    chk("queue_empty", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/neo_d0_outregs.md
NEO_D0_OUTREGS -- requirements
Module: neo_d0_outregs

Interface
REQ-001 SHALL have parameter NCH, default 2, number of output-port channels (1..6).
REQ-002 SHALL have parameter CW, default 3, bits per output channel.
REQ-003 SHALL have parameter BANK_W, default 3, width of the bank register.
REQ-004 SHALL have parameter DW, default 8, 68k data width used (DW >= max(CW, BANK_W, NCH)).
REQ-005 SHALL have parameter SELW, default 2, register-select width (2^SELW >= NCH+2).
REQ-006 SHALL have parameter PULSE_LEN, default 16, pulse-mode hold time in clocks (1..2^16-1).
REQ-007 SHALL have port CLK_24M, in, 1, the only clock; all state changes on its rising edge.
REQ-008 SHALL have port nRESET, in, 1; reset is synchronous and active-low.
REQ-009 SHALL have port nRESETP, in, 1, output gate: low forces BNK and P_OUT to 0.
REQ-010 SHALL have port nBITWD0, in, 1, asynchronous active-low 68k write strobe.
REQ-011 SHALL have port M68K_ADDR_SEL, in, SELW, register select, stable while nBITWD0 low.
REQ-012 SHALL have port M68K_DATA, in, DW, write data, stable while nBITWD0 low.
REQ-013 SHALL have port BNK, out, BANK_W, bank register.
REQ-014 SHALL have port P_OUT, out, NCH*CW; channel k on bits [k*CW +: CW].
REQ-015 SHALL have port WR_ACK, out, 1, one-clock pulse per accepted write.
REQ-016 SHALL have port BUSY, out, NCH; bit k high while channel k pulse timer runs.

Function
REQ-017 SHALL pass nBITWD0 through a 2-flop synchroniser, then a third flop for edge detection; a write event is synchronised value 0 with previous synchronised value 1.
REQ-018 SHALL capture M68K_ADDR_SEL/M68K_DATA in the write-event cycle and update the target register on the next edge; WR_ACK is high in the cycle after that edge; strobe-falling to register update = 3 clocks max, 2 min.
REQ-019 SHALL require nBITWD0 low >= 2 clocks and high >= 2 clocks between writes; one event per falling edge regardless of low duration.
REQ-020 SHALL decode select: 0 -> bank reg (DATA[BANK_W-1:0]); 1..NCH -> channel sel-1 (DATA[CW-1:0]); NCH+1 -> mode reg (DATA[NCH-1:0], bit k=1 pulse mode); other values -> no update, no WR_ACK.
REQ-021 Level mode: channel output SHALL equal its register, held until next write.
REQ-022 Pulse mode, nonzero write: register loads data, 16-bit counter loads PULSE_LEN, BUSY[k]=1; counter decrements each clock; on the clock where counter goes 1->0 the register clears to 0 and BUSY[k] drops.
REQ-023 Pulse mode, zero write: register=0, counter=0, BUSY[k]=0 on the update edge.
REQ-024 Write to a busy pulse channel SHALL retrigger: new data, counter reloaded to PULSE_LEN.
REQ-025 Mode write pulse->level for channel k: counter cleared, BUSY[k]=0, register value retained.
REQ-026 Mode write level->pulse for channel k: if register nonzero, counter loads PULSE_LEN and BUSY[k]=1; else no change.
REQ-027 nRESETP low SHALL force BNK and P_OUT to 0 combinationally; registers, counters, BUSY, WR_ACK keep operating.
REQ-028 Output width rule: unused upper DATA bits ignored; no sign extension.

Reset
REQ-029 nRESET low at a rising edge: bank, channel, mode regs = 0, counters = 0, BUSY = 0, WR_ACK = 0, sync/edge flops = 1.
REQ-030 After reset, an armed flag (reset 0) SHALL set only once synchronised strobe is seen high; write events while unarmed are discarded (strobe held low across reset never writes).
REQ-031 Reset mid-pulse or mid-write SHALL abort: state as REQ-029 on that edge, no WR_ACK.

Verification
REQ-032 Defaults; write sel=0 data=0x05 -> BNK=3'b101 within 3 clocks, one WR_ACK pulse.
REQ-033 Write sel=1 data=0x06 level mode -> P_OUT[2:0]=3'b110 held 1000 clocks; nRESETP low -> P_OUT=0, high -> 3'b110 again.
REQ-034 Mode=0x02, write sel=2 data=0x03 -> P_OUT[5:3]=3'b011, BUSY=2'b10 for exactly 16 clocks then both 0; retrigger at clock 10 -> hold extends to 26 clocks from first update.
REQ-035 Strobe low 50 clocks -> exactly one write; sel=3'b11 with NCH=2 and SELW=2 hits mode reg; with SELW=3, sel=5 -> no update, no WR_ACK.
REQ-036 nBITWD0 low during and after nRESET release -> no write; nRESET mid-pulse -> BUSY=0, P_OUT=0 next edge.
